nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder built around one 4-bit ripple adder slice
//   (fulladder4). The slice is instantiated once; operands are latched and

---
 rtl/nibble_serial_adder_if.sv | 25 ++
 rtl/nibble_serial_adder.sv | 155 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The master side supplies operands and consumes results.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;

  modport master (
    output valid_i, a_i, b_i, carry_i, ready_i,
    input  ready_o, valid_o, sum_o, carry_o
  );

  modport slave (
    input  valid_i, a_i, b_i, carry_i, ready_i,
    output ready_o, valid_o, sum_o, carry_o
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses a single 4-bit ripple slice,
// one nibble per clock, LSB first. The nibble carry is kept in a register
// and fed back as the next slice carry-in.

// 4-bit ripple-carry adder slice.
module fulladder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c_s;

  // Ripple the carry through the four bit positions.
  always_comb begin
    c_s[0] = ci;
    s      = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c_s[i];
      c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c_s[4];
endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  nibble_serial_adder_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [CW+1:0]    nib_lo_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [3:0]       slice_a_s;
  logic [3:0]       slice_b_s;
  logic [3:0]       slice_sum_s;
  logic             slice_co_s;

  // Bit offset of the nibble currently being added.
  assign nib_lo_s = {cnt_r, 2'b00};

  // Select the current operand nibbles for the shared slice.
  always_comb begin
    slice_a_s = a_r[nib_lo_s +: 4];
    slice_b_s = b_r[nib_lo_s +: 4];
  end

  fulladder4 u_slice (
    .a  (slice_a_s),
    .b  (slice_b_s),
    .ci (carry_r),
    .s  (slice_sum_s),
    .co (slice_co_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode: accept in IDLE, NIB slice steps, then hold the result.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.valid_i) begin
          state_next_s = CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_CNT) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, per-nibble accumulation and carry feedback.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.valid_i) begin
            a_r     <= bus.a_i;
            b_r     <= bus.b_i;
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= bus.carry_i;
            cnt_r   <= {CW{1'b0}};
          end
        end
        CALC: begin
          sum_r[nib_lo_s +: 4] <= slice_sum_s;
          carry_r              <= slice_co_s;
          if (cnt_r == LAST_CNT) begin
            cnt_r <= {CW{1'b0}};
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.ready_o = (state_r == IDLE);
  assign bus.valid_o = (state_r == DONE);
  assign bus.sum_o   = sum_r;
  assign bus.carry_o = carry_r;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH=32 (directed + random) and
// WIDTH=8 (random). A transaction-level model per instance predicts
// handshake timing and the exact (WIDTH+1)-bit sum every cycle.
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst32_n = 1'b1;
  logic rst8_n  = 1'b1;
  bit   done8   = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(32)) bus32 ();
  nibble_serial_adder_if #(.WIDTH(8))  bus8 ();

  nibble_serial_adder #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_ni(rst32_n), .bus(bus32));
  nibble_serial_adder #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_ni(rst8_n),  .bus(bus8));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state, one slot per instance (0: WIDTH=32, 1: WIDTH=8).
  bit          busy [2];
  int          age [2];
  bit          acc_p [2];
  bit          done_p [2];
  int          completed [2];
  logic [63:0] exp_full [2];
  logic [63:0] pend_full [2];
  logic [63:0] last_full [2];

  // One op outstanding at most; result valid NIB edges after acceptance.
  task automatic model_step(input int d, input int w, input logic rst_n,
                            input logic rdy_o, input logic vld_o,
                            input logic [63:0] sum, input logic co,
                            input logic vld_i, input logic rdy_i,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic ci);
    logic [63:0] mask;
    logic [63:0] got;
    int nib;
    mask = (64'd1 << w) - 64'd1;
    nib  = w / 4;
    got  = (64'(co) << w) | (sum & mask);
    if (!rst_n) begin
      busy[d] = 1'b0; age[d] = 0; acc_p[d] = 1'b0; done_p[d] = 1'b0;
      last_full[d] = 64'd0;
      chk($sformatf("w%0d_rst_ready", w), 64'(rdy_o), 64'd1);
      chk($sformatf("w%0d_rst_valid", w), 64'(vld_o), 64'd0);
      chk($sformatf("w%0d_rst_result", w), got, 64'd0);
    end else begin
      if (acc_p[d]) begin
        busy[d] = 1'b1; age[d] = 0; exp_full[d] = pend_full[d];
      end else if (busy[d]) begin
        age[d]++;
      end
      if (done_p[d]) begin
        busy[d] = 1'b0; last_full[d] = exp_full[d]; completed[d]++;
      end
      acc_p[d] = 1'b0; done_p[d] = 1'b0;
      chk($sformatf("w%0d_ready", w), 64'(rdy_o), 64'(!busy[d]));
      chk($sformatf("w%0d_valid", w), 64'(vld_o), 64'(busy[d] && age[d] >= nib));
      if (busy[d] && age[d] >= nib) begin
        chk($sformatf("w%0d_result", w), got, exp_full[d]);
      end else if (!busy[d]) begin
        chk($sformatf("w%0d_idle_result", w), got, last_full[d]);
      end
      if (!busy[d] && vld_i) begin
        acc_p[d] = 1'b1;
        pend_full[d] = (a & mask) + (b & mask) + 64'(ci);
      end
      if (busy[d] && age[d] >= nib && rdy_i) begin
        done_p[d] = 1'b1;
      end
    end
  endtask

  // Compare both instances against the model away from the active edge.
  always @(negedge clk) begin
    model_step(0, 32, rst32_n, bus32.ready_o, bus32.valid_o, 64'(bus32.sum_o),
               bus32.carry_o, bus32.valid_i, bus32.ready_i, 64'(bus32.a_i),
               64'(bus32.b_i), bus32.carry_i);
    model_step(1, 8, rst8_n, bus8.ready_o, bus8.valid_o, 64'(bus8.sum_o),
               bus8.carry_o, bus8.valid_i, bus8.ready_i, 64'(bus8.a_i),
               64'(bus8.b_i), bus8.carry_i);
  end

  function automatic logic [31:0] pick32();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = 32'hFFFF_FFFF;
      1:       v = 32'h0000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Directed op on the 32-bit instance with literal expectations.
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [31:0] exp_s, input logic exp_c,
                      input int hold);
    int n;
    int lat;
    n = 0;
    while (bus32.ready_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready"}, 64'(bus32.ready_o), 64'd1);
    bus32.valid_i = 1'b1; bus32.a_i = a; bus32.b_i = b;
    bus32.carry_i = c; bus32.ready_i = 1'b0;
    @(posedge clk); #1;
    bus32.valid_i = 1'b0; bus32.a_i = $urandom; bus32.b_i = $urandom;
    bus32.carry_i = ~c;
    lat = 0;
    while (bus32.valid_o !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_sum"}, 64'(bus32.sum_o), 64'(exp_s));
    chk({tag, "_carry"}, 64'(bus32.carry_o), 64'(exp_c));
    for (int k = 0; k < hold; k++) begin
      bus32.valid_i = ~bus32.valid_i;
      bus32.a_i = $urandom;
      @(posedge clk); #1;
      chk({tag, "_hold_sum"}, 64'(bus32.sum_o), 64'(exp_s));
      chk({tag, "_hold_carry"}, 64'(bus32.carry_o), 64'(exp_c));
      chk({tag, "_hold_valid"}, 64'(bus32.valid_o), 64'd1);
      chk({tag, "_hold_ready"}, 64'(bus32.ready_o), 64'd0);
    end
    bus32.valid_i = 1'b0; bus32.ready_i = 1'b1;
    @(posedge clk); #1;
    bus32.ready_i = 1'b0;
    if (hold > 0) begin
      chk({tag, "_release_ready"}, 64'(bus32.ready_o), 64'd1);
      chk({tag, "_release_valid"}, 64'(bus32.valid_o), 64'd0);
    end
  endtask

  // Main sequence: 32-bit directed tests, 32-bit random, then summary.
  initial begin
    int cyc;
    bus32.valid_i = 1'b0; bus32.a_i = 32'd0; bus32.b_i = 32'd0;
    bus32.carry_i = 1'b0; bus32.ready_i = 1'b0;
    #2 rst32_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(bus32.ready_o), 64'd1);
    chk("reset_valid", 64'(bus32.valid_o), 64'd0);
    chk("reset_sum", 64'(bus32.sum_o), 64'd0);
    chk("reset_carry", 64'(bus32.carry_o), 64'd0);
    rst32_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the third CALC cycle drops the operation.
    bus32.valid_i = 1'b1; bus32.a_i = 32'h1234_5678; bus32.b_i = 32'h9ABC_DEF0;
    bus32.carry_i = 1'b1;
    @(posedge clk); #1;
    bus32.valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst32_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(bus32.valid_o), 64'd0);
    chk("midreset_ready", 64'(bus32.ready_o), 64'd1);
    chk("midreset_sum", 64'(bus32.sum_o), 64'd0);
    chk("midreset_carry", 64'(bus32.carry_o), 64'd0);
    @(posedge clk); #1;
    rst32_n = 1'b1;
    op32("after_reset", 32'd5, 32'd7, 1'b0, 32'h0000_000C, 1'b0, 0);

    op32("one_plus_two", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 0);
    op32("ripple_all", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0);
    op32("max_plus_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    op32("msb_only", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 0);
    op32("done_hold", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 5);

    cyc = 0;
    while (completed[0] < 1000 && cyc < 40000) begin
      bus32.valid_i = ($urandom_range(0, 2) != 0);
      bus32.a_i = pick32();
      bus32.b_i = pick32();
      bus32.carry_i = 1'($urandom_range(0, 1));
      bus32.ready_i = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1; cyc++;
    end
    chk("w32_random_ops", 64'(completed[0] >= 1000), 64'd1);
    bus32.valid_i = 1'b0; bus32.ready_i = 1'b1;

    cyc = 0;
    while (!done8 && cyc < 60000) begin
      @(posedge clk); cyc++;
    end
    chk("w8_driver_done", 64'(done8), 64'd1);
    chk("w8_random_ops", 64'(completed[1] >= 1000), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Random traffic for the 8-bit instance.
  initial begin
    int cyc;
    logic [31:0] t;
    bus8.valid_i = 1'b0; bus8.a_i = 8'd0; bus8.b_i = 8'd0;
    bus8.carry_i = 1'b0; bus8.ready_i = 1'b0;
    #2 rst8_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst8_n = 1'b1;
    cyc = 0;
    while (completed[1] < 1000 && cyc < 40000) begin
      bus8.valid_i = ($urandom_range(0, 2) != 0);
      t = pick32();
      bus8.a_i = t[7:0];
      t = pick32();
      bus8.b_i = t[7:0];
      bus8.carry_i = 1'($urandom_range(0, 1));
      bus8.ready_i = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1; cyc++;
    end
    bus8.valid_i = 1'b0; bus8.ready_i = 1'b1;
    done8 = 1'b1;
  end
endmodule
